branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution checker for the RV32 core. In fetch it looks up the current PC in a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters and supplies a predicted next PC. In execute it takes the resolved outcome from the branch condition unit (`br_taken`, same `br_type` encoding), updates the tables, and raises a redirect when the prediction was wrong. It also keeps branch and mispredict statistics counters.

## Interface
- ENTRIES, 64: BTB entries; must be a power of 2, ≥ 4.
- IDX_W, $clog2(ENTRIES): index width (derived, do not override).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- if_pc  input  32  fetch-stage PC, word aligned.
- pred_taken  output  1  fetch prediction: take the branch.
- pred_target  output  32  predicted next PC.
- ex_valid  input  1  a valid instruction occupies EX this cycle.
- ex_pc  input  32  PC of the EX instruction.
- ex_br_type  input  3  branch type:
  - 000 none
  - 001 eq
  - 010 ge
  - 011 geu
  - 100 lt
  - 101 ltu
  - 110 ne
  - 111 unconditional jump
- ex_br_taken  input  1  resolved outcome from the branch condition unit.
- ex_target  input  32  resolved branch/jump target.
- ex_pred_taken  input  1  prediction carried with the EX instruction.
- ex_pred_target  input  32  predicted target carried with the EX instruction.
- mispredict  output  1  EX prediction was wrong; flush IF/ID this cycle.
- redirect_pc  output  32  correct next PC when `mispredict` is 1.
- br_count  output  32  number of resolved branches and jumps.
- mp_count  output  32  number of mispredicts.

## Operation
- Entry fields: `valid`, `tag` = pc[31:IDX_W+2], `target`[31:0], `ctr`[1:0].
- Fetch index: if_pc[IDX_W+1:2]. An entry hits when it is valid and its tag matches.
- Lookup is combinational from the registered array:
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc + 4.
- "Branch" below means ex_valid && ex_br_type != 000.
- Mispredict is combinational:
  - For a branch: ex_br_taken != ex_pred_taken, or (ex_br_taken && ex_target != ex_pred_target).
  - For ex_valid && ex_br_type == 000: ex_pred_taken == 1 (stale entry).
  - Otherwise 0.
- redirect_pc = ex_br_taken && ex_br_type != 000 ? ex_target : ex_pc + 4. It is 32-bit wrapping (0xFFFFFFFC + 4 = 0).
- Table update on the clock edge, at index ex_pc[IDX_W+1:2]:
  - Branch, entry hit:
    - taken: ctr = min(ctr+1, 3) and target = ex_target.
    - not taken: ctr = max(ctr-1, 0), target unchanged.
  - Branch, entry miss, taken: allocate with valid=1, tag, target = ex_target, ctr = 11 for br_type 111, else 10. This overwrites any existing entry.
  - Branch, entry miss, not taken: no change.
  - Non-branch with ex_pred_taken=1: clear valid of the hit entry.
- Counters:
  - br_count increments on every branch.
  - mp_count increments on every cycle with mispredict=1.
  - Both saturate at 0xFFFFFFFF.

## Timing
- Lookup latency is 0 cycles (same-cycle combinational). Mispredict and redirect are also 0 cycles after the EX inputs.
- Updates become visible to lookup on the cycle after the update edge.
- Same-index read and write in one cycle: fetch sees the pre-update contents.
- Reset, in one clocked cycle:
  - all valid = 0, all ctr = 01, br_count = 0, mp_count = 0.
- Outputs after reset:
  - pred_taken = 0, pred_target = if_pc + 4.
  - mispredict is combinational and follows its inputs; the pipeline holds ex_valid = 0 during reset.
- Reset mid-operation: reset has priority over any update in the same cycle. No table state survives.
- ex_valid = 0: no update, mispredict = 0, counters hold.
- Array is register based, not SRAM, so every entry can be reset.

## Test plan
- **Reset:** assert rst 1 cycle, then if_pc = 0x100 → pred_taken = 0, pred_target = 0x104, br_count = mp_count = 0.
- **Cold taken branch:** ex_pc = 0x100, br_type 001, taken, target 0x80, pred_taken 0 → mispredict = 1, redirect_pc = 0x80.
  - Next cycle, if_pc = 0x100 → pred_taken = 1, pred_target = 0x80.
  - mp_count = 1, br_count = 1.
- **Saturation/hysteresis:** after the allocation above, resolve two more taken (ctr 11), then one not-taken → ctr 10, still predicts taken. A second not-taken → ctr 01, pred_taken = 0.
- **Wrong target:** hit entry predicts 0x80, resolved taken to 0x90 → mispredict = 1, redirect_pc = 0x90. Next lookup gives pred_target = 0x90.
- **Stale entry:** ex_br_type 000, ex_pred_taken 1, ex_pc 0x100 → mispredict = 1, redirect_pc = 0x104. Next cycle the 0x100 lookup misses.
- **Alias and simultaneous events:** with ENTRIES = 64, 0x100 and 0x200 share an index.
  - A taken jump at 0x200 evicts the 0x100 entry.
  - In that same cycle, if_pc = 0x100 still hits the old entry.
  - Asserting rst in that same cycle leaves the table empty next cycle.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: fetch-time prediction,
// execute-time resolution/redirect, table update and branch/mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  ex_br_type,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_reg    [ENTRIES];
  logic [31:0]        target_reg [ENTRIES];
  logic [1:0]         ctr_reg    [ENTRIES];
  logic [31:0]        br_count_reg;
  logic [31:0]        mp_count_reg;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             if_hit;
  logic             ex_hit;
  logic             is_branch;
  logic             is_plain;

  logic             upd_en;
  logic             valid_next;
  logic [TAG_W-1:0] tag_next;
  logic [31:0]      target_next;
  logic [1:0]       ctr_next;

  // Byte-offset bits of the word-aligned PCs carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx    = if_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_tag    = ex_pc[31:IDX_W+2];
  assign if_hit    = valid_reg[if_idx] && (tag_reg[if_idx] == if_pc[31:IDX_W+2]);
  assign ex_hit    = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);
  assign is_branch = ex_valid && (ex_br_type != 3'b000);
  assign is_plain  = ex_valid && (ex_br_type == 3'b000);

  assign pred_taken  = if_hit && ctr_reg[if_idx][1];
  assign pred_target = pred_taken ? target_reg[if_idx] : if_pc + 32'd4;

  always_comb begin
    mispredict = 1'b0;
    if (is_branch)
      mispredict = (ex_br_taken != ex_pred_taken) ||
                   (ex_br_taken && (ex_target != ex_pred_target));
    else if (is_plain)
      mispredict = ex_pred_taken;
  end

  assign redirect_pc = (ex_br_taken && (ex_br_type != 3'b000)) ? ex_target : ex_pc + 32'd4;

  // Next contents of the entry at ex_idx; unchanged fields default to the current entry.
  always_comb begin
    upd_en      = 1'b0;
    valid_next  = valid_reg[ex_idx];
    tag_next    = tag_reg[ex_idx];
    target_next = target_reg[ex_idx];
    ctr_next    = ctr_reg[ex_idx];
    if (is_branch) begin
      if (ex_hit) begin
        upd_en = 1'b1;
        if (ex_br_taken) begin
          ctr_next    = (ctr_reg[ex_idx] == 2'b11) ? 2'b11 : ctr_reg[ex_idx] + 2'd1;
          target_next = ex_target;
        end else begin
          ctr_next = (ctr_reg[ex_idx] == 2'b00) ? 2'b00 : ctr_reg[ex_idx] - 2'd1;
        end
      end else if (ex_br_taken) begin
        upd_en      = 1'b1;
        valid_next  = 1'b1;
        tag_next    = ex_tag;
        target_next = ex_target;
        ctr_next    = (ex_br_type == 3'b111) ? 2'b11 : 2'b10;
      end
    end else if (is_plain && ex_pred_taken && ex_hit) begin
      upd_en     = 1'b1;
      valid_next = 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi]  <= 1'b0;
          tag_reg[gi]    <= '0;
          target_reg[gi] <= '0;
          ctr_reg[gi]    <= 2'b01;
        end else if (upd_en && (ex_idx == IDX_W'(gi))) begin
          valid_reg[gi]  <= valid_next;
          tag_reg[gi]    <= tag_next;
          target_reg[gi] <= target_next;
          ctr_reg[gi]    <= ctr_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_reg <= '0;
      mp_count_reg <= '0;
    end else begin
      if (is_branch && (br_count_reg != 32'hFFFF_FFFF))
        br_count_reg <= br_count_reg + 32'd1;
      if (mispredict && (mp_count_reg != 32'hFFFF_FFFF))
        mp_count_reg <= mp_count_reg + 32'd1;
    end
  end

  assign br_count = br_count_reg;
  assign mp_count = mp_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against a behavioural table model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_br_type;
  logic        ex_br_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_type(ex_br_type), .ex_br_taken(ex_br_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
  );

  // Behavioural model: one record per table slot, counters kept as plain integers.
  typedef struct {
    bit        valid;
    bit [31:0] tag;
    bit [31:0] target;
    int        ctr;
  } ent_t;

  ent_t    m[ENTRIES];
  longint  m_br;
  longint  m_mp;

  function automatic int m_index(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i = m_index(pc);
    return m[i].valid && (m[i].tag == pc / (4 * ENTRIES));
  endfunction

  function automatic void m_pred(input logic [31:0] pc, output bit t, output bit [31:0] tgt);
    int i = m_index(pc);
    t   = m_hit(pc) && (m[i].ctr >= 2);
    tgt = t ? m[i].target : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    if (!ex_valid) return 1'b0;
    if (ex_br_type == 3'd0) return ex_pred_taken;
    return (ex_br_taken != ex_pred_taken) || (ex_br_taken && ex_target != ex_pred_target);
  endfunction

  function automatic bit [31:0] m_redirect();
    return (ex_br_taken && ex_br_type != 3'd0) ? ex_target : ex_pc + 32'd4;
  endfunction

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    bit mp  = m_mispredict();
    int i   = m_index(ex_pc);
    bit hit = m_hit(ex_pc);
    $display("txn t=%0t rst=%0b v=%0b pc=%h type=%0d tk=%0b tgt=%h ptk=%0b mp=%0b",
             $time, rst, ex_valid, ex_pc, ex_br_type, ex_br_taken, ex_target, ex_pred_taken, mp);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m[k].valid = 1'b0;
        m[k].ctr   = 1;
      end
      m_br = 0;
      m_mp = 0;
    end else if (ex_valid) begin
      if (ex_br_type != 3'd0) begin
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (hit) begin
          if (ex_br_taken) begin
            m[i].ctr    = (m[i].ctr + 1 > 3) ? 3 : m[i].ctr + 1;
            m[i].target = ex_target;
          end else begin
            m[i].ctr = (m[i].ctr - 1 < 0) ? 0 : m[i].ctr - 1;
          end
        end else if (ex_br_taken) begin
          m[i].valid  = 1'b1;
          m[i].tag    = ex_pc / (4 * ENTRIES);
          m[i].target = ex_target;
          m[i].ctr    = (ex_br_type == 3'd7) ? 3 : 2;
        end
      end else if (ex_pred_taken && hit) begin
        m[i].valid = 1'b0;
      end
      if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
    #1;
  endtask

  task automatic set_ex(bit v, logic [31:0] pc, logic [2:0] ty, bit tk, logic [31:0] tgt,
                        bit ptk, logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_br_type = ty; ex_br_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    if_pc = 32'h100;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %h exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h exp 104", pred_target); end
    checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL reset_br_count got %h exp 0", br_count); end
    checks++; if (mp_count !== 32'd0) begin errors++; $display("FAIL reset_mp_count got %h exp 0", mp_count); end
  endtask

  task automatic test_cold_taken();
    set_ex(1, 32'h100, 3'd1, 1, 32'h80, 0, 32'h104);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL cold_mispredict got %h exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL cold_redirect got %h exp 80", redirect_pc); end
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL cold_pred_taken got %h exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL cold_pred_target got %h exp 80", pred_target); end
    checks++; if (mp_count !== 32'd1) begin errors++; $display("FAIL cold_mp_count got %0d exp 1", mp_count); end
    checks++; if (br_count !== 32'd1) begin errors++; $display("FAIL cold_br_count got %0d exp 1", br_count); end
  endtask

  task automatic test_hysteresis();
    for (int n = 0; n < 2; n++) begin
      set_ex(1, 32'h100, 3'd1, 1, 32'h80, 1, 32'h80);
      #1;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL hyst_correct_mp got %h exp 0", mispredict); end
      tick();
    end
    set_ex(1, 32'h100, 3'd1, 0, 32'h80, 1, 32'h80);
    #1;
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL hyst_nt_redirect got %h exp 104", redirect_pc); end
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL hyst_ctr10_pred got %h exp 1", pred_taken); end
    set_ex(1, 32'h100, 3'd1, 0, 32'h80, 1, 32'h80);
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL hyst_ctr01_pred got %h exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL hyst_ctr01_target got %h exp 104", pred_target); end
    checks++; if (br_count !== 32'd5) begin errors++; $display("FAIL hyst_br_count got %0d exp 5", br_count); end
    checks++; if (mp_count !== 32'd3) begin errors++; $display("FAIL hyst_mp_count got %0d exp 3", mp_count); end
  endtask

  task automatic test_wrong_target();
    set_ex(1, 32'h100, 3'd1, 1, 32'h80, 0, 32'h104);
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL wt_pre_target got %h exp 80", pred_target); end
    set_ex(1, 32'h100, 3'd1, 1, 32'h90, 1, 32'h80);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL wt_mispredict got %h exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h90) begin errors++; $display("FAIL wt_redirect got %h exp 90", redirect_pc); end
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_target !== 32'h90) begin errors++; $display("FAIL wt_new_target got %h exp 90", pred_target); end
  endtask

  task automatic test_stale();
    set_ex(1, 32'h100, 3'd0, 0, 32'h0, 1, 32'h90);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL stale_mispredict got %h exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL stale_redirect got %h exp 104", redirect_pc); end
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL stale_lookup got %h exp 0", pred_taken); end
  endtask

  task automatic test_alias();
    set_ex(1, 32'h100, 3'd1, 1, 32'h80, 0, 32'h104);
    tick();
    if_pc = 32'h100;
    set_ex(1, 32'h200, 3'd7, 1, 32'h300, 0, 32'h204);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_same_cycle_taken got %h exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alias_same_cycle_target got %h exp 80", pred_target); end
    tick();
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted got %h exp 0", pred_taken); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL alias_jump_target got %h exp 300", pred_target); end
    rst = 1'b1;
    set_ex(1, 32'h100, 3'd7, 1, 32'h80, 0, 32'h104);
    tick();
    rst = 1'b0;
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_rst_0x200 got %h exp 0", pred_taken); end
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_rst_0x100 got %h exp 0", pred_taken); end
    checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL alias_rst_br_count got %0d exp 0", br_count); end
  endtask

  task automatic test_idle_and_wrap();
    set_ex(0, 32'h100, 3'd1, 1, 32'h40, 0, 32'h104);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL idle_mispredict got %h exp 0", mispredict); end
    tick();
    #1;
    checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL idle_br_count got %0d exp 0", br_count); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL idle_no_update got %h exp 0", pred_taken); end
    if_pc = 32'hFFFF_FFFC;
    set_ex(1, 32'hFFFF_FFFC, 3'd0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_redirect got %h exp 0", redirect_pc); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL wrap_pred_target got %h exp 0", pred_target); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] tpool [4];
    bit          et;
    bit [31:0]   etg;
    pool  = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h1100, 32'h208, 32'hFFFF_FFFC, 32'h40};
    tpool = '{32'h80, 32'h90, 32'h300, 32'h1000};
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      if_pc         = pool[$urandom_range(0, 7)];
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_pc         = pool[$urandom_range(0, 7)];
      ex_br_type    = 3'($urandom_range(0, 7));
      ex_br_taken   = (ex_br_type == 3'd7) ? 1'b1 : 1'($urandom_range(0, 1));
      ex_target     = tpool[$urandom_range(0, 3)];
      m_pred(ex_pc, et, etg);
      if ($urandom_range(0, 3) == 0) begin
        et  = ~et;
        etg = tpool[$urandom_range(0, 3)];
      end
      ex_pred_taken  = et;
      ex_pred_target = etg;
      #1;
      m_pred(if_pc, et, etg);
      checks++; if (pred_taken !== et) begin errors++; $display("FAIL rnd_pred_taken n=%0d got %h exp %h", n, pred_taken, et); end
      checks++; if (pred_target !== etg) begin errors++; $display("FAIL rnd_pred_target n=%0d got %h exp %h", n, pred_target, etg); end
      checks++; if (mispredict !== m_mispredict()) begin errors++; $display("FAIL rnd_mispredict n=%0d got %h exp %h", n, mispredict, m_mispredict()); end
      checks++; if (redirect_pc !== m_redirect()) begin errors++; $display("FAIL rnd_redirect n=%0d got %h exp %h", n, redirect_pc, m_redirect()); end
      tick();
      checks++; if (br_count !== 32'(m_br)) begin errors++; $display("FAIL rnd_br_count n=%0d got %0d exp %0d", n, br_count, m_br); end
      checks++; if (mp_count !== 32'(m_mp)) begin errors++; $display("FAIL rnd_mp_count n=%0d got %0d exp %0d", n, mp_count, m_mp); end
    end
    rst = 1'b0;
    set_ex(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_cold_taken();
    test_hysteresis();
    test_wrong_target();
    test_stale();
    test_alias();
    test_idle_and_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
